// File: rtl/key_pkg.sv
// Shared definitions for the key debounce block: FSM state encoding,
// default filter length and counter sizing helper.
package key_pkg;

    typedef logic [1:0] key_state_t;

    localparam key_state_t REL    = 2'd0;
    localparam key_state_t WAIT_P = 2'd1;
    localparam key_state_t PRS    = 2'd2;
    localparam key_state_t WAIT_R = 2'd3;

    // 20 ms at 50 MHz
    localparam int DEFAULT_CNT_MAX = 1_000_000;

    function automatic int cnt_width(input int cnt_max);
        return $clog2(cnt_max);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, four-state filter FSM with a
// saturating stability counter, and registered level/press/release outputs.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int                CW       = cnt_width(CNT_MAX);
    localparam logic [CW-1:0]     CNT_LAST = CW'(CNT_MAX - 1);

    logic [1:0]    r_sync;
    logic          w_s;
    key_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;

    // Key is active-low; invert before synchronising so 0 means released.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, exactly like the hardware.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], ~key_in};
        end
    end

    assign w_s = r_sync[1];

    // A level is accepted once CNT_MAX consecutive samples agree, so the
    // cap check comes before the bounce check on the accepting edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= REL;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                REL: begin
                    if (w_s) begin
                        r_state <= WAIT_P;
                        r_cnt   <= '0;
                    end
                end
                WAIT_P: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= PRS;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else if (!w_s) begin
                        r_state <= REL;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRS: begin
                    if (!w_s) begin
                        r_state <= WAIT_R;
                        r_cnt   <= '0;
                    end
                end
                WAIT_R: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state   <= REL;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else if (w_s) begin
                        r_state <= PRS;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= REL;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign key_level   = r_level;
    assign key_press   = r_press;
    assign key_release = r_release;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key conditioner: CH_NUM independent debounce channels.
module key_debounce
    import key_pkg::*;
#(
    parameter int CH_NUM  = 2,
    parameter int CNT_MAX = DEFAULT_CNT_MAX
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [CH_NUM-1:0] key_in,
    output logic [CH_NUM-1:0] key_level,
    output logic [CH_NUM-1:0] key_press,
    output logic [CH_NUM-1:0] key_release
);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        key_debounce_ch #(
            .CNT_MAX (CNT_MAX)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst     (sys_rst),
            .key_in      (key_in[g]),
            .key_level   (key_level[g]),
            .key_press   (key_press[g]),
            .key_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=4, CH_NUM=2; outputs are
// sampled 1 ns after each rising edge, k counts edges after stimulus.
module tb_key_debounce;

    localparam int CH_NUM  = 2;
    localparam int CNT_MAX = 4;
    localparam int ACC_K   = CNT_MAX + 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [CH_NUM-1:0] key_in;
    logic [CH_NUM-1:0] key_level;
    logic [CH_NUM-1:0] key_press;
    logic [CH_NUM-1:0] key_release;

    int errors = 0;
    int checks = 0;

    key_debounce #(
        .CH_NUM  (CH_NUM),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        logic [5:0] got, exp;
        sys_rst = 1'b1;
        key_in  = 2'b11;
        repeat (3) tick;
        got = {key_level, key_press, key_release};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL reset_poweron: got lvl/prs/rel=%b expected %b", got, 6'b0);
        end
        sys_rst = 1'b0;
        key_in  = 2'b00;
        repeat (12) tick;
        checks++;
        if (key_level !== 2'b11) begin
            errors++;
            $display("FAIL reset_precond: got level=%b expected 11", key_level);
        end
        sys_rst = 1'b1;
        #1;
        got = {key_level, key_press, key_release};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: got lvl/prs/rel=%b expected %b", got, 6'b0);
        end
        for (int k = 1; k <= 3; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL reset_held k=%0d: got lvl/prs/rel=%b expected %b", k, got, 6'b0);
            end
        end
        sys_rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            exp = {(k >= ACC_K) ? 2'b11 : 2'b00, (k == ACC_K) ? 2'b11 : 2'b00, 2'b00};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_after k=%0d: got lvl/prs/rel=%b expected %b", k, got, exp);
            end
        end
        key_in = 2'b11;
        repeat (10) tick;
    endtask

    task automatic test_clean_press;
        logic [5:0] got, exp;
        key_in[0] = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            exp = {1'b0, k >= ACC_K, 1'b0, k == ACC_K, 2'b00};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_press k=%0d: got lvl/prs/rel=%b expected %b", k, got, exp);
            end
        end
        key_in[0] = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            exp = {1'b0, k < ACC_K, 2'b00, 1'b0, k == ACC_K};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_release k=%0d: got lvl/prs/rel=%b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_bounce;
        logic [5:0] got;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                key_in[1] = (c < 3) ? 1'b0 : 1'b1;
                tick;
                got = {key_level, key_press, key_release};
                checks++;
                if (got !== 6'b0) begin
                    errors++;
                    $display("FAIL bounce r=%0d c=%0d: got lvl/prs/rel=%b expected %b", r, c, got, 6'b0);
                end
            end
        end
        for (int k = 1; k <= 8; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL bounce_tail k=%0d: got lvl/prs/rel=%b expected %b", k, got, 6'b0);
            end
        end
    endtask

    task automatic test_threshold;
        logic [5:0] got, exp;
        key_in[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick;
            if (k == CNT_MAX - 1) key_in[0] = 1'b1;
            got = {key_level, key_press, key_release};
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL thresh_short k=%0d: got lvl/prs/rel=%b expected %b", k, got, 6'b0);
            end
        end
        // Press accepted at k=7; release filter starts one edge later.
        key_in[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick;
            if (k == CNT_MAX) key_in[0] = 1'b1;
            got = {key_level, key_press, key_release};
            exp = {1'b0, (k >= ACC_K) && (k < ACC_K + CNT_MAX + 1),
                   1'b0, k == ACC_K, 1'b0, k == ACC_K + CNT_MAX + 1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL thresh_exact k=%0d: got lvl/prs/rel=%b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_simultaneous;
        logic [5:0] got, exp;
        key_in = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            exp = {(k >= ACC_K) ? 2'b11 : 2'b00, (k == ACC_K) ? 2'b11 : 2'b00, 2'b00};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simul_press k=%0d: got lvl/prs/rel=%b expected %b", k, got, exp);
            end
        end
        key_in = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            exp = {(k >= ACC_K) ? 2'b10 : 2'b11, 2'b00, (k == ACC_K) ? 2'b01 : 2'b00};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL simul_rel0 k=%0d: got lvl/prs/rel=%b expected %b", k, got, exp);
            end
        end
        key_in = 2'b11;
        repeat (10) tick;
        checks++;
        if (key_level !== 2'b00) begin
            errors++;
            $display("FAIL simul_idle: got level=%b expected 00", key_level);
        end
    endtask

    task automatic test_reset_mid_filter;
        logic [5:0] got, exp;
        key_in[0] = 1'b0;
        repeat (5) tick;
        got = {key_level, key_press, key_release};
        checks++;
        if (got !== 6'b0) begin
            errors++;
            $display("FAIL midrst_pre: got lvl/prs/rel=%b expected %b", got, 6'b0);
        end
        sys_rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            checks++;
            if (got !== 6'b0) begin
                errors++;
                $display("FAIL midrst_held k=%0d: got lvl/prs/rel=%b expected %b", k, got, 6'b0);
            end
        end
        sys_rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick;
            got = {key_level, key_press, key_release};
            exp = {1'b0, k >= ACC_K, 1'b0, k == ACC_K, 2'b00};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL midrst_after k=%0d: got lvl/prs/rel=%b expected %b", k, got, exp);
            end
        end
        key_in = 2'b11;
        repeat (10) tick;
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_threshold;
        test_simultaneous;
        test_reset_mid_filter;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
